// File: rtl/issue_scheduler_pkg.sv
// Shared constants and types for the decode-side issue scheduler.
// Latencies are in clock cycles measured from the issue cycle.
package issue_scheduler_pkg;

    localparam int REGISTER_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** REGISTER_WIDTH;
    localparam int LOAD_USE_CNT   = 1;
    localparam int MUL_USE_CNT    = 4;
    localparam int ALU_WB_DIST    = 3;
    localparam int MUL_WB_DIST    = 6;
    localparam int CNT_W          = $clog2(MUL_USE_CNT + 1);

    typedef logic [REGISTER_WIDTH-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]          pend_cnt_t;

    // Decoded-instruction view, driven directly by the decode stage.
    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     rs1_needed;
        logic     rs2_needed;
        logic     is_mul;
        logic     is_load;
        logic     is_wb;
        reg_idx_t rd;
    } sched_req_t;

    function automatic pend_cnt_t use_cnt(input logic is_mul);
        return is_mul ? pend_cnt_t'(MUL_USE_CNT) : pend_cnt_t'(LOAD_USE_CNT);
    endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode <-> issue scheduler bundle: decoded request in, issue/stall decision out.
// Signal names keep the scheduler's point of view (_i into it, _o out of it).
interface issue_scheduler_if;
    import issue_scheduler_pkg::*;

    logic        dec_valid_i;
    logic        flush_i;
    sched_req_t  req_i;
    logic        issue_o;
    logic        stall_o;
    logic        stall_raw_o;
    logic        stall_waw_o;
    logic        stall_wb_o;
    logic [31:0] stall_cycles_o;

    modport master (
        output dec_valid_i, flush_i, req_i,
        input  issue_o, stall_o, stall_raw_o, stall_waw_o, stall_wb_o, stall_cycles_o
    );

    modport slave (
        input  dec_valid_i, flush_i, req_i,
        output issue_o, stall_o, stall_raw_o, stall_waw_o, stall_wb_o, stall_cycles_o
    );

endinterface

// File: rtl/issue_scheduler_reg_pending_table.sv
// Per-register "not yet bypassable" down-counters with three read ports,
// one load port and a global decrement. Register x0 is never tracked.
module issue_scheduler_reg_pending_table
    import issue_scheduler_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  reg_idx_t  i_rs1,
    input  reg_idx_t  i_rs2,
    input  reg_idx_t  i_rd,
    output logic      o_rs1_busy,
    output logic      o_rs2_busy,
    output logic      o_rd_busy,
    input  logic      i_load,
    input  reg_idx_t  i_load_idx,
    input  pend_cnt_t i_load_val,
    input  logic      i_dec
);

    pend_cnt_t r_cnt [NUM_REGS];

    // A load into a counter takes priority over its decrement in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (i_load && (i_load_idx == reg_idx_t'(r))) begin
                    r_cnt[r] <= i_load_val;
                end else if (i_dec && (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - pend_cnt_t'(1);
                end
            end
        end
    end

    assign o_rs1_busy = (r_cnt[i_rs1] != '0);
    assign o_rs2_busy = (r_cnt[i_rs2] != '0);
    assign o_rd_busy  = (r_cnt[i_rd]  != '0);

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: decides each cycle whether the decoded instruction issues or
// stalls on RAW, WAW or write-port conflicts, and counts stall cycles.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter logic [31:0] STALL_CNT_RST = '0
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    issue_scheduler_if.slave sched
);

    sched_req_t              w_req;
    logic                    w_req_valid;
    logic                    w_rs1_busy;
    logic                    w_rs2_busy;
    logic                    w_rd_busy;
    logic                    w_rd_nz;
    logic                    w_raw;
    logic                    w_waw;
    logic                    w_wbc;
    logic                    w_stall;
    logic                    w_issue;
    logic                    w_tbl_load;
    logic [MUL_WB_DIST:1]    w_slot_set;
    logic [MUL_WB_DIST:1]    r_slot;
    logic [31:0]             r_stall_cycles;

    assign w_req       = sched.req_i;
    assign w_req_valid = sched.dec_valid_i & ~sched.flush_i;
    assign w_rd_nz     = (w_req.rd != '0);

    issue_scheduler_reg_pending_table u_pending (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_rs1      (w_req.rs1),
        .i_rs2      (w_req.rs2),
        .i_rd       (w_req.rd),
        .o_rs1_busy (w_rs1_busy),
        .o_rs2_busy (w_rs2_busy),
        .o_rd_busy  (w_rd_busy),
        .i_load     (w_tbl_load),
        .i_load_idx (w_req.rd),
        .i_load_val (use_cnt(w_req.is_mul)),
        .i_dec      (1'b1)
    );

    assign w_raw = (w_req.rs1_needed & w_rs1_busy) | (w_req.rs2_needed & w_rs2_busy);
    assign w_waw = w_req.is_wb & w_rd_nz & w_rd_busy;
    assign w_wbc = w_req.is_wb & ~w_req.is_mul & r_slot[ALU_WB_DIST];

    assign w_stall = w_req_valid & (w_raw | w_waw | w_wbc);
    assign w_issue = w_req_valid & ~w_stall;

    // Plain ALU results are bypassed from the ALU stage, so only loads and muls occupy the table.
    assign w_tbl_load = w_issue & w_req.is_wb & w_rd_nz & (w_req.is_load | w_req.is_mul);

    // Reservation is placed at its distance from the issuing cycle, then ages with the ring.
    always_comb begin
        w_slot_set = r_slot;
        if (w_issue && w_req.is_wb) begin
            if (w_req.is_mul) begin
                w_slot_set[MUL_WB_DIST] = 1'b1;
            end else begin
                w_slot_set[ALU_WB_DIST] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_set >> 1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cycles <= STALL_CNT_RST;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign sched.issue_o        = w_issue;
    assign sched.stall_o        = w_stall;
    assign sched.stall_raw_o    = w_req_valid & w_raw;
    assign sched.stall_waw_o    = w_req_valid & w_waw;
    assign sched.stall_wb_o     = w_req_valid & w_wbc;
    assign sched.stall_cycles_o = r_stall_cycles;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: per-cycle vector table plus hand sequences
// for mid-operation reset and stall-counter saturation.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    localparam int K_IDLE  = 0;
    localparam int K_ALU   = 1;
    localparam int K_ALUI  = 2;
    localparam int K_LOAD  = 3;
    localparam int K_MUL   = 4;
    localparam int K_STORE = 5;

    // {issue, stall, raw, waw, wb}
    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_ISSUE = 5'b10000;
    localparam logic [4:0] E_RAW   = 5'b01100;
    localparam logic [4:0] E_WAW   = 5'b01010;
    localparam logic [4:0] E_WB    = 5'b01001;
    localparam logic [4:0] E_RAWWB = 5'b01101;
    localparam logic [4:0] E_WAWWB = 5'b01011;

    typedef struct {
        logic        valid;
        logic        flush;
        sched_req_t  req;
        logic [4:0]  exp;
        logic [31:0] cnt;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    vec_t vecs[$];

    issue_scheduler_if u_if ();
    issue_scheduler_if u_if2 ();

    issue_scheduler u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .sched (u_if)
    );

    issue_scheduler #(.STALL_CNT_RST(32'hFFFF_FFFD)) u_dut_sat (
        .clk_i (clk),
        .rst_i (rst),
        .sched (u_if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int kind, input int rs1, input int rs2, input int rd,
                                input logic flush, input logic [4:0] exp, input logic [31:0] cnt);
        vec_t v;
        v.valid          = (kind != K_IDLE);
        v.flush          = flush;
        v.req.rs1        = reg_idx_t'(rs1);
        v.req.rs2        = reg_idx_t'(rs2);
        v.req.rs1_needed = (kind != K_IDLE);
        v.req.rs2_needed = (kind == K_ALU) || (kind == K_MUL) || (kind == K_STORE);
        v.req.is_mul     = (kind == K_MUL);
        v.req.is_load    = (kind == K_LOAD);
        v.req.is_wb      = (kind == K_ALU) || (kind == K_ALUI) || (kind == K_LOAD) || (kind == K_MUL);
        v.req.rd         = reg_idx_t'(rd);
        v.exp            = exp;
        v.cnt            = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put(input int which, input vec_t v);
        if (which == 0) begin
            u_if.dec_valid_i = v.valid;
            u_if.flush_i     = v.flush;
            u_if.req_i       = v.req;
        end else begin
            u_if2.dec_valid_i = v.valid;
            u_if2.flush_i     = v.flush;
            u_if2.req_i       = v.req;
        end
    endtask

    task automatic chk(input int which, input string name, input vec_t v);
        if (which == 0) begin
            check({name, " outs"}, 32'({u_if.issue_o, u_if.stall_o, u_if.stall_raw_o,
                                        u_if.stall_waw_o, u_if.stall_wb_o}), 32'(v.exp));
            check({name, " stall_cycles"}, u_if.stall_cycles_o, v.cnt);
        end else begin
            check({name, " outs"}, 32'({u_if2.issue_o, u_if2.stall_o, u_if2.stall_raw_o,
                                        u_if2.stall_waw_o, u_if2.stall_wb_o}), 32'(v.exp));
            check({name, " stall_cycles"}, u_if2.stall_cycles_o, v.cnt);
        end
    endtask

    task automatic step(input int which, input string name, input vec_t v);
        @(negedge clk);
        put(which, v);
        #1;
        chk(which, name, v);
    endtask

    initial begin
        vec_t idle;
        n_cmp = 0;
        n_err = 0;
        idle  = mk(K_IDLE, 0, 0, 0, 1'b0, E_NONE, 0);
        put(0, idle);
        put(1, idle);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk(0, "reset", idle);
        check("reset preload stall_cycles", u_if2.stall_cycles_o, 32'hFFFF_FFFD);

        // load-use
        vecs.push_back(mk(K_IDLE,  0, 0, 0,  1'b0, E_NONE,  0));
        vecs.push_back(mk(K_LOAD,  1, 0, 5,  1'b0, E_ISSUE, 0));
        vecs.push_back(mk(K_ALU,   5, 0, 6,  1'b0, E_RAW,   0));
        vecs.push_back(mk(K_ALU,   5, 0, 6,  1'b0, E_ISSUE, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(K_IDLE, 0, 0, 0, 1'b0, E_NONE, 1));
        // mul-use; third stall cycle also collides with the mul write-back slot
        vecs.push_back(mk(K_MUL,   1, 2, 7,  1'b0, E_ISSUE, 1));
        vecs.push_back(mk(K_ALU,   7, 3, 11, 1'b0, E_RAW,   1));
        vecs.push_back(mk(K_ALU,   7, 3, 11, 1'b0, E_RAW,   2));
        vecs.push_back(mk(K_ALU,   7, 3, 11, 1'b0, E_RAWWB, 3));
        vecs.push_back(mk(K_ALU,   7, 3, 11, 1'b0, E_RAW,   4));
        vecs.push_back(mk(K_ALU,   7, 3, 11, 1'b0, E_ISSUE, 5));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(K_IDLE, 0, 0, 0, 1'b0, E_NONE, 5));
        // write-port structural conflict
        vecs.push_back(mk(K_MUL,   1, 2, 8,  1'b0, E_ISSUE, 5));
        vecs.push_back(mk(K_IDLE,  0, 0, 0,  1'b0, E_NONE,  5));
        vecs.push_back(mk(K_ALUI,  1, 0, 9,  1'b0, E_ISSUE, 5));
        vecs.push_back(mk(K_ALUI,  1, 0, 9,  1'b0, E_WB,    5));
        vecs.push_back(mk(K_ALUI,  1, 0, 9,  1'b0, E_ISSUE, 6));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(K_IDLE, 0, 0, 0, 1'b0, E_NONE, 6));
        // WAW against in-flight mul
        vecs.push_back(mk(K_MUL,   1, 2, 10, 1'b0, E_ISSUE, 6));
        vecs.push_back(mk(K_ALUI,  1, 0, 10, 1'b0, E_WAW,   6));
        vecs.push_back(mk(K_ALUI,  1, 0, 10, 1'b0, E_WAW,   7));
        vecs.push_back(mk(K_ALUI,  1, 0, 10, 1'b0, E_WAWWB, 8));
        vecs.push_back(mk(K_ALUI,  1, 0, 10, 1'b0, E_WAW,   9));
        vecs.push_back(mk(K_ALUI,  1, 0, 10, 1'b0, E_ISSUE, 10));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(K_IDLE, 0, 0, 0, 1'b0, E_NONE, 10));
        // x0 is never tracked
        vecs.push_back(mk(K_MUL,   1, 2, 0,  1'b0, E_ISSUE, 10));
        vecs.push_back(mk(K_ALU,   0, 0, 0,  1'b0, E_ISSUE, 10));
        vecs.push_back(mk(K_ALUI,  0, 0, 0,  1'b0, E_ISSUE, 10));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(K_IDLE, 0, 0, 0, 1'b0, E_NONE, 10));
        // flush beats stall and leaves no table/ring footprint
        vecs.push_back(mk(K_MUL,   1, 2, 7,  1'b0, E_ISSUE, 10));
        vecs.push_back(mk(K_ALU,   7, 3, 11, 1'b1, E_NONE,  10));
        vecs.push_back(mk(K_MUL,   1, 2, 14, 1'b1, E_NONE,  10));
        vecs.push_back(mk(K_STORE, 14, 2, 0, 1'b0, E_ISSUE, 10));
        vecs.push_back(mk(K_IDLE,  0, 0, 0,  1'b0, E_NONE,  10));
        vecs.push_back(mk(K_ALUI,  1, 0, 15, 1'b0, E_ISSUE, 10));
        vecs.push_back(mk(K_IDLE,  0, 0, 0,  1'b0, E_NONE,  10));

        foreach (vecs[i]) begin
            step(0, $sformatf("vec%0d", i), vecs[i]);
        end

        // reset in the shadow of a mul clears the pending state
        step(0, "mid_rst mul", mk(K_MUL, 1, 2, 7, 1'b0, E_ISSUE, 10));
        @(negedge clk);
        rst = 1'b1;
        put(0, idle);
        #1;
        check("mid_rst outs during reset", 32'({u_if.issue_o, u_if.stall_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        put(0, mk(K_ALU, 7, 3, 11, 1'b0, E_ISSUE, 0));
        #1;
        chk(0, "mid_rst dependent", mk(K_ALU, 7, 3, 11, 1'b0, E_ISSUE, 0));
        step(0, "mid_rst idle", idle);

        // saturating counter on the preloaded instance
        step(1, "sat mul",   mk(K_MUL, 1, 2, 7, 1'b0, E_ISSUE, 32'hFFFF_FFFD));
        step(1, "sat st1",   mk(K_ALU, 7, 3, 11, 1'b0, E_RAW,   32'hFFFF_FFFD));
        step(1, "sat st2",   mk(K_ALU, 7, 3, 11, 1'b0, E_RAW,   32'hFFFF_FFFE));
        step(1, "sat st3",   mk(K_ALU, 7, 3, 11, 1'b0, E_RAWWB, 32'hFFFF_FFFF));
        step(1, "sat st4",   mk(K_ALU, 7, 3, 11, 1'b0, E_RAW,   32'hFFFF_FFFF));
        step(1, "sat issue", mk(K_ALU, 7, 3, 11, 1'b0, E_ISSUE, 32'hFFFF_FFFF));
        step(1, "sat idle",  mk(K_IDLE, 0, 0, 0, 1'b0, E_NONE,  32'hFFFF_FFFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Issue controller between the decode stage and the split execution back end: an ALU→MEM→WB path and a 5‑stage multiplier EX1..EX5→WB.
- Holds a per‑register pending table and a write‑back slot reservation ring.
- Each cycle it decides whether the decoded instruction may issue, or must stall on one of three hazards:
  - RAW hazards not coverable by bypass (load‑use, mul‑use);
  - WAW ordering against in‑flight long‑latency writes;
  - structural conflicts on the single register‑file write port.
- Sits beside the decode stage; its `stall_o` freezes fetch/decode registers.

## Interface
- `REGISTER_WIDTH`, 5 — register index width; 2**REGISTER_WIDTH registers, x0 never tracked.
- `LOAD_USE_CNT`, 1 — cycles a load result is unavailable to an immediately following consumer.
- `MUL_USE_CNT`, 4 — cycles a mul result is unavailable (bypass available from EX5).
- `ALU_WB_DIST`, 3 — cycles from issue to WB on the ALU/MEM path.
- `MUL_WB_DIST`, 6 — cycles from issue to WB on the mul path.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  synchronous, active‑high reset.
- `dec_valid_i`  in  1  decode holds a valid instruction.
- `flush_i`  in  1  jump/branch‑taken kill of the decode instruction.
- `rs1_i`, `rs2_i`  in  REGISTER_WIDTH  source indices.
- `rs1_needed_i`, `rs2_needed_i`  in  1  operand actually read.
- `is_mul_i`  in  1  routes to the mul path.
- `is_load_i`  in  1  load.
- `is_wb_i`  in  1  writes `rd`.
- `rd_i`  in  REGISTER_WIDTH  destination.
- `issue_o`  out  1  instruction leaves decode this cycle.
- `stall_o`  out  1  hold decode/fetch.
- `stall_raw_o`, `stall_waw_o`, `stall_wb_o`  out  1  individual causes.
- `stall_cycles_o`  out  32  saturating count of `stall_o` cycles.

## Operation
- Pending table: one `$clog2(MUL_USE_CNT+1)`‑bit down‑counter `cnt[r]` per register. Non‑zero means r is not yet bypassable.
- `req = dec_valid_i & ~flush_i`.
- `raw = (rs1_needed_i & cnt[rs1_i]!=0) | (rs2_needed_i & cnt[rs2_i]!=0)`.
- `waw = is_wb_i & rd_i!=0 & cnt[rd_i]!=0`.
- WB ring: `slot[k]`, k=1..MUL_WB_DIST; bit k set means the write port is reserved k cycles from now.
  - `wbc = is_wb_i & ~is_mul_i & slot[ALU_WB_DIST]`.
  - A mul can never collide, since its distance is the longest.
- `stall_o = req & (raw|waw|wbc)`; `issue_o = req & ~stall_o`. Cause outputs are the individual terms ANDed with `req`.
- On `issue_o` with `is_wb_i & rd_i!=0`:
  - load: `cnt[rd]` ← LOAD_USE_CNT;
  - mul: `cnt[rd]` ← MUL_USE_CNT;
  - other ALU op: no table write (ALU‑stage bypass).
- On `issue_o` with `is_wb_i`: set `slot[MUL_WB_DIST]` (mul) or `slot[ALU_WB_DIST]` (ALU path), applied after the shift.
- Every cycle: all non‑zero counters decrement; the ring shifts down by one and `slot[1]` drops out.
- Issue load of `cnt[rd]` overrides the same‑cycle decrement. No conflict arises in practice, because the WAW stall guarantees `cnt[rd]==0` at issue.
- `flush_i` wins over stall: outputs are 0 and no reservations are made. In‑flight state is untouched.
- Stores and branches: no table write, no reservation.

## Timing
- Fully combinational `issue_o`/`stall_o` from inputs and state; no added latency.
- State updates on `clk_i` rising edge.
- Reset (including mid‑operation): all `cnt` = 0, ring = 0, `stall_cycles_o` = 0. Outputs are then purely combinational, so they are 0 while `dec_valid_i` = 0.
- Load at t, dependent at t+1: stalls 1 cycle, issues at t+2 using the MEM‑stage bypass.
- Mul at t: dependent stalls through t+4 and issues at t+5 (EX5 bypass). WB of the mul is at t+6.
- Mul at t, ALU wb op at t+3: stalls 1 cycle on `wbc` and issues at t+4 (WB t+7).
- `stall_cycles_o` saturates at 32'hFFFF_FFFF and does not wrap.

## Structure
- `params_pkg` additions:
  - constants LOAD_USE_CNT, MUL_USE_CNT, ALU_WB_DIST, MUL_WB_DIST;
  - typedef `sched_req_t` bundling rs1/rs2/needed/is_mul/is_load/is_wb/rd, so decode can drive it directly from its hazard signals.
- One sub‑module `reg_pending_table`: the counter array with two read ports (rs1, rs2), a third read for rd, one load port and a global decrement.
- Ring, hazard logic and perf counter stay in the top.

## Test plan
- Reset then idle: all outputs 0; after `rst_i` asserted mid‑mul‑shadow, a dependent issues the next cycle with no stall.
- LOAD x5 at t, ADD x6←x5 at t+1 → `stall_raw_o`=1 for 1 cycle, `issue_o` at t+2; `stall_cycles_o`=1.
- MUL x7 at t, ADD reading x7 at t+1 → stall t+1..t+4, issue at t+5; `stall_cycles_o`=4.
- MUL x8 at t, ADDI x9 (independent) at t+3 → `stall_wb_o`=1 at t+3, issue at t+4; ADDI at t+2 issues without stall.
- MUL x10 at t, ADDI x10 at t+1 → `stall_waw_o` until `cnt[x10]`=0, issue at t+5; rd=x0 never stalls or tracks.
- Hazarded instruction with `flush_i`=1 → `stall_o`=0, `issue_o`=0, no table/ring change; saturating counter preloaded near max holds at 32'hFFFF_FFFF.
